// File: rtl/sha_pkg.sv
// SHA-256 shared types, round constants and round/schedule helper functions.
package sha_pkg;

  typedef struct packed {
    logic [31:0] a, b, c, d, e, f, g, h;
  } HashState;

  // Round constants, index 0 is the leftmost entry.
  localparam logic [0:63][31:0] K256 = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Initial hash value; used by benches to seed and finalise a block.
  localparam HashState IV = '{
    a: 32'h6a09e667, b: 32'hbb67ae85, c: 32'h3c6ef372, d: 32'ha54ff53a,
    e: 32'h510e527f, f: 32'h9b05688c, g: 32'h1f83d9ab, h: 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // One compression round with schedule word w and round constant k.
  function automatic HashState sha_round_fn(input HashState s, input logic [31:0] w,
                                            input logic [31:0] k);
    logic [31:0] t1, t2;
    HashState    n;
    t1 = s.h + bsig1(s.e) + ch(s.e, s.f, s.g) + k + w;
    t2 = bsig0(s.a) + maj(s.a, s.b, s.c);
    n  = '{a: t1 + t2, b: s.a, c: s.b, d: s.c, e: s.d + t1, f: s.e, g: s.f, h: s.g};
    return n;
  endfunction

  // Slide the 16-word schedule window by one; the new word enters at index 15.
  function automatic logic [15:0][31:0] sha_expand(input logic [15:0][31:0] w);
    logic [15:0][31:0] nw;
    nw = {ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0], w[15:1]};
    return nw;
  endfunction

endpackage

// File: rtl/sha_round_stage.sv
// One registered SHA-256 round plus one schedule-window shift, with elastic handshake.
module sha_round_stage
  import sha_pkg::*;
#(
  parameter int R = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  HashState          state_i,
  input  logic [15:0][31:0] window_i,
  input  logic              valid_i,
  input  logic              newblock_i,
  input  logic              ready_in,
  output logic              ready_out,
  output HashState          state_o,
  output logic [15:0][31:0] window_o,
  output logic              valid_o,
  output logic              newblock_o
);

  HashState          state_q, state_d;
  logic [15:0][31:0] win_q, win_d;
  logic              vld_q, nb_q;

  assign state_d   = sha_round_fn(state_i, window_i[0], K256[R]);
  assign win_d     = sha_expand(window_i);
  // An empty stage always accepts, so bubbles get overwritten.
  assign ready_out = ~vld_q | ready_in;

  // Load on ready; payload only moves for a real beat to avoid needless toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      win_q   <= '0;
      vld_q   <= 1'b0;
      nb_q    <= 1'b0;
    end else if (ready_out) begin
      vld_q <= valid_i;
      nb_q  <= valid_i & newblock_i;
      if (valid_i) begin
        state_q <= state_d;
        win_q   <= win_d;
      end
    end
  end

  assign state_o    = state_q;
  assign window_o   = win_q;
  assign valid_o    = vld_q;
  assign newblock_o = nb_q;

endmodule

// File: rtl/sha_round_segment.sv
// Elastic chain of DEPTH SHA-256 rounds starting at round START.
module sha_round_segment
  import sha_pkg::*;
#(
  parameter int START = 0,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  HashState          state_i,
  input  logic [15:0][31:0] window_i,
  input  logic              valid_i,
  input  logic              newblock_i,
  output logic              ready_o,
  output HashState          state_o,
  output logic [15:0][31:0] window_o,
  output logic              valid_o,
  output logic              newblock_o,
  input  logic              ready_i
);

  if (DEPTH < 1 || START < 0 || START + DEPTH > 64) begin : g_bad_params
    $error("sha_round_segment: START=%0d DEPTH=%0d exceeds 64 rounds", START, DEPTH);
  end

  // Index 0 is the segment input, index DEPTH the segment output.
  HashState [DEPTH:0]          st_pipe;
  logic     [DEPTH:0][15:0][31:0] win_pipe;
  logic     [DEPTH:0]          vld_pipe;
  logic     [DEPTH:0]          nb_pipe;
  logic     [DEPTH:0]          rdy_pipe;

  assign st_pipe[0]      = state_i;
  assign win_pipe[0]     = window_i;
  assign vld_pipe[0]     = valid_i;
  assign nb_pipe[0]      = newblock_i;
  assign rdy_pipe[DEPTH] = ready_i;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    sha_round_stage #(.R(START + k)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .state_i   (st_pipe[k]),
      .window_i  (win_pipe[k]),
      .valid_i   (vld_pipe[k]),
      .newblock_i(nb_pipe[k]),
      .ready_in  (rdy_pipe[k+1]),
      .ready_out (rdy_pipe[k]),
      .state_o   (st_pipe[k+1]),
      .window_o  (win_pipe[k+1]),
      .valid_o   (vld_pipe[k+1]),
      .newblock_o(nb_pipe[k+1])
    );
  end

  assign ready_o    = rdy_pipe[0];
  assign state_o    = st_pipe[DEPTH];
  assign window_o   = win_pipe[DEPTH];
  assign valid_o    = vld_pipe[DEPTH];
  assign newblock_o = nb_pipe[DEPTH];

endmodule

// File: doc/sha_round_segment.md
# sha_round_segment

Parametrised, elastic SHA-256 compression segment: DEPTH consecutive rounds starting at round START, one registered round per stage. The block carries the 16-word message-schedule window and expands it on the fly, so only the block's first 16 words enter at round 0. It adds valid/ready back-pressure with bubble collapse. Segments chain back-to-back; four DEPTH=16 segments form a complete 64-round compression core.

## Interface
Parameters:
- START, 0: index of the first round computed (0..63).
- DEPTH, 4: number of rounds and pipeline stages (1..64). START+DEPTH must be ≤ 64; elaboration-time assertion.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- state_i  in  HashState  working variables a..h entering round START.
- window_i  in  32x16  schedule window; word 0 = W[START], word 15 = W[START+15].
- valid_i  in  1  input beat valid.
- newblock_i  in  1  sideband tag, travels with the beat.
- ready_o  out  1  segment can accept a beat this cycle.
- state_o  out  HashState  working variables after round START+DEPTH-1.
- window_o  out  32x16  window advanced DEPTH positions; word 0 = W[START+DEPTH].
- valid_o  out  1  output beat valid.
- newblock_o  out  1  tag of the output beat.
- ready_i  in  1  downstream accepts the output beat.

## Operation
- Stage k (0..DEPTH-1) computes round r = START+k:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K256[r] + w[0]
  - T2 = Σ0(a) + Maj(a,b,c)
  - next state = {T1+T2, a, b, c, d+T1, e, f, g}
- All additions are mod 2^32; carries are discarded.
- Window shift per stage: new = σ1(w[14]) + w[9] + σ0(w[1]) + w[0], all mod 2^32.
  - next window = {new, w[15:1]}: words move down one index, and new enters at index 15.
  - Expansion runs unconditionally, including rounds ≥ 48, where the result is unused but harmless.
- Each stage has a registered state, window, valid and newblock.
- Stage handshake:
  - stage_ready[k] = ~valid[k] | stage_ready[k+1].
  - stage_ready[DEPTH] = ready_i.
  - ready_o = stage_ready[0].
- A stage loads when stage_ready[k] is 1. It captures the upstream valid as its own valid, so bubbles are overwritten.
- A stage holds its contents when stage_ready[k] is 0.
- When a stage loads, its upstream payload is registered only if the upstream valid is 1. Otherwise the data registers are don't-care; hold them to save toggle.
- A beat is accepted when valid_i & ready_o. A beat leaves when valid_o & ready_i. Order is strictly FIFO, with no duplication or loss.
- newblock has no functional effect inside the segment; it is delay-matched only.

## Timing
- Reset (rst_n low, asynchronous):
  - all valid and newblock registers go to 0; state and window registers go to 0.
  - outputs: valid_o=0, newblock_o=0, state_o=0, window_o=0, ready_o=1.
- Latency: an accepted beat appears on valid_o exactly DEPTH cycles later when no stall occurs.
- Throughput: 1 beat/cycle while ready_i=1.
- ready_o is combinational from ready_i and the stage valids. The path depth is DEPTH; the integrator pipelines across segment boundaries if this is timing-critical.
- Full pipeline with ready_i=0: ready_o=0, and all outputs are held stable.
- Simultaneous accept and emit on a full pipeline with ready_i=1: both occur in the same cycle with no bubble.
- Empty stages with ready_i=0: upstream beats advance until they reach the first occupied stage (bubble collapse).
- Reset asserted mid-stream: all in-flight beats are discarded. After release, the first accepted beat behaves as from an empty pipeline.
- valid_i must not depend combinationally on ready_o.

## Structure
- sha_pkg holds:
  - HashState: packed struct a..h, 32 bits each.
  - K256[0:63] constant array.
  - functions Ch, Maj, Σ0, Σ1, σ0, σ1, and a sha_round_fn returning the next HashState.
  - the IV constant, for benches.
- Sub-module sha_round_stage, parameter R:
  - contains one round, one window shift, and one set of payload/valid registers.
  - stage ports: ready_in and ready_out.
- sha_round_segment is a generate loop of DEPTH sha_round_stage instances with R=START+k.

## Test plan
- **Single round:** START=0, DEPTH=1. Drive state_i=IV and the padded "abc" block (w0=61626380, w15=00000018), with ready_i=1.
  - Next cycle: valid_o=1.
  - state_o a=5d6aebcd, b=6a09e667, e=fa2a4622, h=1f83d9ab.
  - window_o[15]=61626380.
- **Full compression:** chain four DEPTH=16 segments (START=0,16,32,48) on the same "abc" input.
  - After 64 cycles: a=506e3058, b=d39a2165, c=04d24d6c, d=b85e2ce9, e=5ef50f24, f=fb121210, g=948d25b6, h=961f4894.
  - Bench adds IV: result ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- **Back-pressure:** DEPTH=4, stream 8 distinct blocks, with ready_i=0 for 3 cycles after the 2nd output.
  - All 8 outputs are emitted in order, with none lost or duplicated.
  - ready_o drops only while all 4 stages are valid.
  - Outputs are stable during the stall.
- **Bubbles:** DEPTH=4, valid_i=1 on alternating cycles, ready_i=1.
  - valid_o shows the same alternating pattern delayed 4 cycles.
  - Then hold ready_i=0 for 4 cycles: bubbles collapse and ready_o falls only after 4 beats are held.
- **Sideband:** newblock_i=1 on beats 1 and 3 of 4.
  - newblock_o=1 exactly on output beats 1 and 3, including across a stall.
- **Reset mid-stream:** with 3 beats in flight, pulse rst_n low between clock edges.
  - valid_o=0 and ready_o=1 immediately, with no beat emitted afterwards.
  - A fresh beat emerges DEPTH cycles after acceptance.
